comparator_array_2: RTL and testbench

Combinational-compare, registered-output dictionary match block for the Stage-1 compressor. It compares one input word against every dictionary entry, classifies the best match by byte-prefix length, and reports the match type, a match-valid flag and the winning entry index. It sits between the dictionary storage and the code/encoding generator.

---
 rtl/comparator_array_2.sv | 71 +++++++
 tb/tb_comparator_array_2.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/comparator_array_2.sv
// Dictionary match block: compares one input word against every dictionary entry,
// picks the best byte-prefix match (highest index on ties) and registers the result.
module comparator_array_2 #(
  parameter int INPUT_WORD = 32,
  parameter int DICT_ENTRY = 16,
  parameter int DICT_WORD  = 32,
  localparam int LOC_W     = $clog2(DICT_ENTRY)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [INPUT_WORD-1:0]            i_input,
  input  logic [INPUT_WORD*DICT_ENTRY-1:0] i_dict,
  output logic [1:0]                       o_type_matched,
  output logic                             o_align,
  output logic [LOC_W-1:0]                 o_location
);

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_MMXX = 2'b01;
  localparam logic [1:0] CLS_MMMX = 2'b10;
  localparam logic [1:0] CLS_FULL = 2'b11;

  // Class of one entry: longest matching byte prefix, most significant byte first.
  function automatic logic [1:0] match_class(input logic [INPUT_WORD-1:0] word,
                                             input logic [DICT_WORD-1:0]  entry);
    logic [1:0] cls;
    cls = CLS_NONE;
    if (word == entry)                  cls = CLS_FULL;
    else if (word[31:8]  == entry[31:8])  cls = CLS_MMMX;
    else if (word[31:16] == entry[31:16]) cls = CLS_MMXX;
    return cls;
  endfunction

  logic [1:0]       type_matched_d, type_matched_q;
  logic             align_d, align_q;
  logic [LOC_W-1:0] location_d, location_q;

  // Ascending scan with >= lets a later (higher-index) entry of equal class win.
  always_comb begin
    logic [1:0] cls;
    type_matched_d = CLS_NONE;
    location_d     = '0;
    cls            = CLS_NONE;
    for (int k = 0; k < DICT_ENTRY; k++) begin
      cls = match_class(i_input, i_dict[(DICT_ENTRY-1-k)*DICT_WORD +: DICT_WORD]);
      if (cls != CLS_NONE && cls >= type_matched_d) begin
        type_matched_d = cls;
        location_d     = LOC_W'(k);
      end
    end
    align_d = (type_matched_d != CLS_NONE);
  end

  // Output register stage; reset clears every output and discards that cycle's compare.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      type_matched_q <= CLS_NONE;
      align_q        <= 1'b0;
      location_q     <= '0;
    end else begin
      type_matched_q <= type_matched_d;
      align_q        <= align_d;
      location_q     <= location_d;
    end
  end

  assign o_type_matched = type_matched_q;
  assign o_align        = align_q;
  assign o_location     = location_q;

endmodule

// File: tb/tb_comparator_array_2.sv
// Bench for comparator_array_2: directed test-plan vectors plus randomized dictionaries
// checked against a byte-prefix-counting reference model.
module tb_comparator_array_2;

  localparam int DE = 16;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      in_w;
  logic [W*DE-1:0]   dict_flat;
  logic [1:0]        o_type;
  logic              o_align;
  logic [3:0]        o_loc;

  logic [W-1:0]      dict [DE];
  logic [1:0]        exp_type;
  logic              exp_align;
  logic [3:0]        exp_loc;

  int total = 0;
  int bad   = 0;

  comparator_array_2 #(.INPUT_WORD(W), .DICT_ENTRY(DE), .DICT_WORD(W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_input        (in_w),
    .i_dict         (dict_flat),
    .o_type_matched (o_type),
    .o_align        (o_align),
    .o_location     (o_loc)
  );

  always #5 clk = ~clk;

  // Reference: count equal leading bytes, map 4/3/2 bytes to class 3/2/1, then
  // walk from the top index down keeping the first strictly better class.
  task automatic model(input logic [W-1:0] w);
    int n;
    int cls;
    exp_type = 2'b00;
    exp_loc  = 4'd0;
    for (int k = DE - 1; k >= 0; k--) begin
      n = 0;
      for (int b = 3; b >= 0; b--) begin
        if (dict[k][b*8 +: 8] == w[b*8 +: 8]) n++;
        else break;
      end
      cls = (n == 4) ? 3 : (n == 3) ? 2 : (n == 2) ? 1 : 0;
      if (cls > int'(exp_type)) begin
        exp_type = 2'(cls);
        exp_loc  = 4'(k);
      end
    end
    exp_align = (exp_type != 2'b00);
  endtask

  task automatic expect_zero();
    exp_type  = 2'b00;
    exp_align = 1'b0;
    exp_loc   = 4'd0;
  endtask

  task automatic pack();
    for (int k = 0; k < DE; k++) dict_flat[(DE-1-k)*W +: W] = dict[k];
  endtask

  task automatic step();
    pack();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    total++;
    assert (o_type === exp_type) else begin
      bad++;
      $error("FAIL %s type: got %b want %b", tag, o_type, exp_type);
    end
    total++;
    assert (o_align === exp_align) else begin
      bad++;
      $error("FAIL %s align: got %b want %b", tag, o_align, exp_align);
    end
    total++;
    assert (o_loc === exp_loc) else begin
      bad++;
      $error("FAIL %s location: got %0d want %0d", tag, o_loc, exp_loc);
    end
  endtask

  // Fill every entry with a word whose top byte differs from w.
  task automatic fill_nomatch(input logic [W-1:0] w);
    logic [7:0] flip;
    for (int k = 0; k < DE; k++) begin
      flip    = 8'($urandom_range(1, 255));
      dict[k] = {w[31:24] ^ flip, 24'($urandom)};
    end
  endtask

  initial begin
    logic [7:0] flip;
    int         kind;
    rst       = 1'b1;
    in_w      = '0;
    dict_flat = '0;
    for (int k = 0; k < DE; k++) dict[k] = '0;

    // Full match single hit, held in reset for two edges.
    in_w = 32'hA5A5A5A5;
    fill_nomatch(in_w);
    dict[0] = 32'hEEEEEEEE; dict[1] = 32'hDDDDDDDD;
    dict[2] = 32'hCCCCCCCC; dict[3] = 32'hA5A5A5A5;
    step(); expect_zero(); check("reset1");
    step(); expect_zero(); check("reset2");
    rst = 1'b0;
    step(); model(in_w); check("single_hit");
    total++;
    assert (o_type === 2'b11 && o_loc === 4'd3) else begin
      bad++;
      $error("FAIL single_hit_const: got %b/%0d want 11/3", o_type, o_loc);
    end

    // Inputs changing between edges must not disturb the held result.
    in_w = 32'h0BADF00D;
    #3; check("hold_between_edges");

    // Full match at index 10.
    in_w = 32'h55AA55AA;
    fill_nomatch(in_w);
    dict[9] = 32'hAAAAAA55; dict[10] = 32'h55AA55AA;
    step(); model(in_w); check("idx10");

    // No match at all.
    in_w = 32'h12345678;
    for (int k = 0; k < DE; k++) dict[k] = 32'hFFFFFFFF;
    step(); model(in_w); check("no_match");

    // Multiple full hits: highest index wins.
    in_w = 32'hDEADBEEF;
    fill_nomatch(in_w);
    dict[0] = in_w; dict[1] = in_w; dict[7] = in_w;
    step(); model(in_w); check("multi_hit");

    // Class priority, then removing the better classes one at a time.
    in_w = 32'h12345678;
    fill_nomatch(in_w);
    dict[2] = 32'h123456FF; dict[9] = 32'h1234FFFF; dict[5] = 32'h12345678;
    step(); model(in_w); check("prio_full");
    dict[5] = 32'hFF345678;
    step(); model(in_w); check("prio_mmmx");
    dict[2] = 32'hFF3456FF;
    step(); model(in_w); check("prio_mmxx");

    // Zero input word is compared like any other value.
    in_w = 32'h00000000;
    fill_nomatch(in_w);
    dict[15] = 32'h000000FF; dict[4] = 32'h00000000;
    step(); model(in_w); check("zero_word");

    // Reset asserted mid-stream with a matching input.
    in_w = 32'hCAFEBABE;
    fill_nomatch(in_w);
    dict[12] = in_w;
    rst = 1'b1;
    step(); expect_zero(); check("mid_reset");
    rst = 1'b0;
    step(); model(in_w); check("after_mid_reset");

    // Randomized dictionaries with occasional reset edges.
    for (int it = 0; it < 300; it++) begin
      in_w = $urandom;
      for (int k = 0; k < DE; k++) begin
        kind = $urandom_range(0, 5);
        flip = 8'($urandom_range(1, 255));
        case (kind)
          0:       dict[k] = in_w;
          1:       dict[k] = {in_w[31:8], in_w[7:0] ^ flip};
          2:       dict[k] = {in_w[31:16], in_w[15:8] ^ flip, 8'($urandom)};
          default: dict[k] = {in_w[31:24] ^ flip, 24'($urandom)};
        endcase
      end
      rst = ($urandom_range(0, 9) == 0);
      step();
      if (rst) expect_zero();
      else     model(in_w);
      check("random");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
